// File: rtl/acc_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | acc_pkg : command encodings and sequencer states for acc_shift_pair |
// | Revision: 1.0                                                       |
// +-------------------------------------------------------------------+
package acc_pkg;

    localparam logic [2:0] CMD_NOP       = 3'd0;
    localparam logic [2:0] CMD_LD_AH_EXT = 3'd1;
    localparam logic [2:0] CMD_LD_AH_ALU = 3'd2;
    localparam logic [2:0] CMD_XFER      = 3'd3;
    localparam logic [2:0] CMD_SHL1      = 3'd4;
    localparam logic [2:0] CMD_SHR1      = 3'd5;
    localparam logic [2:0] CMD_SHL_N     = 3'd6;
    localparam logic [2:0] CMD_SHR_N     = 3'd7;

    typedef enum logic [0:0] {
        SEQ_IDLE  = 1'b0,
        SEQ_SHIFT = 1'b1
    } seq_state_e;

    function automatic logic is_shift_n(input logic [2:0] c);
        return (c == CMD_SHL_N) || (c == CMD_SHR_N);
    endfunction

endpackage
`default_nettype wire

// File: rtl/acc_shift_seq.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | acc_shift_seq : handshake, shift counter and step/direction strobes |
// | Revision: 1.0                                                       |
// +-------------------------------------------------------------------+
module acc_shift_seq
    import acc_pkg::*;
#(
    parameter int W    = 8,
    parameter int SH_W = $clog2(2*W)+1
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            en,
    input  logic            cmd_valid_i,
    input  logic [2:0]      cmd_i,
    input  logic [SH_W-1:0] shamt_i,
    output logic            accept_o,
    output logic            step_o,
    output logic            shift_left_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            cmd_ready_o
);

    localparam logic [SH_W-1:0] MAX_STEPS = SH_W'(2*W);

    seq_state_e      state_q, state_d;
    logic [SH_W-1:0] cnt_q, cnt_d;
    logic            dir_q, dir_d;
    logic            done_q, done_d;
    logic [SH_W-1:0] w_n_eff;

    assign w_n_eff     = (shamt_i > MAX_STEPS) ? MAX_STEPS : shamt_i;
    assign busy_o      = (state_q == SEQ_SHIFT);
    assign cmd_ready_o = ~busy_o;
    assign done_o      = done_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= SEQ_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    // done_d defaults low so the pulse self-clears even while en is low.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        done_d       = 1'b0;
        step_o       = 1'b0;
        shift_left_o = dir_q;
        accept_o     = en & cmd_valid_i & (state_q == SEQ_IDLE);
        case (state_q)
            SEQ_IDLE: begin
                shift_left_o = (cmd_i == CMD_SHL1) || (cmd_i == CMD_SHL_N);
                if (accept_o) begin
                    if (is_shift_n(cmd_i)) begin
                        if (w_n_eff == '0) begin
                            done_d = 1'b1;
                        end else begin
                            step_o = 1'b1;
                            dir_d  = shift_left_o;
                            cnt_d  = w_n_eff - SH_W'(1);
                            if (w_n_eff == SH_W'(1)) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = SEQ_SHIFT;
                            end
                        end
                    end else begin
                        done_d = 1'b1;
                        step_o = (cmd_i == CMD_SHL1) || (cmd_i == CMD_SHR1);
                    end
                end
            end
            SEQ_SHIFT: begin
                if (en) begin
                    step_o = 1'b1;
                    cnt_d  = cnt_q - SH_W'(1);
                    if (cnt_q == SH_W'(1)) begin
                        state_d = SEQ_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/acc_shift_pair.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | acc_shift_pair : AH/AL accumulator pair shifting as one 2W register |
// | Revision: 1.0                                                       |
// +-------------------------------------------------------------------+
module acc_shift_pair
    import acc_pkg::*;
#(
    parameter int W    = 8,
    parameter int SH_W = $clog2(2*W)+1
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            en,
    input  logic            ah_reset,
    input  logic [2:0]      cmd,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [SH_W-1:0] shamt,
    input  logic            carry_in,
    input  logic [W-1:0]    ah_in,
    input  logic [W-1:0]    aludata,
    output logic [W-1:0]    ah_out,
    output logic [W-1:0]    al_out,
    output logic            shift_out,
    output logic            busy,
    output logic            done
);

    logic [W-1:0]   ah_q, ah_d;
    logic [W-1:0]   al_q, al_d;
    logic           so_q, so_d;
    logic           w_accept;
    logic           w_step;
    logic           w_left;
    logic [2*W-1:0] w_shl;
    logic [2*W-1:0] w_shr;

    acc_shift_seq #(
        .W    (W),
        .SH_W (SH_W)
    ) u_seq (
        .clk          (clk),
        .clr_n        (clr_n),
        .en           (en),
        .cmd_valid_i  (cmd_valid),
        .cmd_i        (cmd),
        .shamt_i      (shamt),
        .accept_o     (w_accept),
        .step_o       (w_step),
        .shift_left_o (w_left),
        .busy_o       (busy),
        .done_o       (done),
        .cmd_ready_o  (cmd_ready)
    );

    assign w_shl = {ah_q[W-2:0], al_q, carry_in};
    assign w_shr = {carry_in, ah_q, al_q[W-1:1]};

    // ah_reset is applied last and outside the enable so it overrides any AH result.
    always_comb begin
        ah_d = ah_q;
        al_d = al_q;
        so_d = so_q;
        if (w_step) begin
            if (w_left) begin
                {ah_d, al_d} = w_shl;
                so_d         = ah_q[W-1];
            end else begin
                {ah_d, al_d} = w_shr;
                so_d         = al_q[0];
            end
        end else if (w_accept) begin
            case (cmd)
                CMD_LD_AH_EXT: ah_d = ah_in;
                CMD_LD_AH_ALU: ah_d = aludata;
                CMD_XFER:      al_d = ah_q;
                default:       ;
            endcase
        end
        if (ah_reset) begin
            ah_d = '0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ah_q <= '0;
            al_q <= '0;
            so_q <= 1'b0;
        end else begin
            ah_q <= ah_d;
            al_q <= al_d;
            so_q <= so_d;
        end
    end

    assign ah_out    = ah_q;
    assign al_out    = al_q;
    assign shift_out = so_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_shift_pair.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_acc_shift_pair : directed bench with a 2W-bit behavioural model  |
// | Revision: 1.0                                                       |
// +-------------------------------------------------------------------+
module tb_acc_shift_pair;
    import acc_pkg::*;

    localparam int W    = 8;
    localparam int SH_W = $clog2(2*W)+1;

    logic            clk = 1'b0;
    logic            clr_n;
    logic            en;
    logic            ah_reset;
    logic [2:0]      cmd;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [SH_W-1:0] shamt;
    logic            carry_in;
    logic [W-1:0]    ah_in;
    logic [W-1:0]    aludata;
    logic [W-1:0]    ah_out;
    logic [W-1:0]    al_out;
    logic            shift_out;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;

    acc_shift_pair #(.W(W), .SH_W(SH_W)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .en        (en),
        .ah_reset  (ah_reset),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .shamt     (shamt),
        .carry_in  (carry_in),
        .ah_in     (ah_in),
        .aludata   (aludata),
        .ah_out    (ah_out),
        .al_out    (al_out),
        .shift_out (shift_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the pair is one 2W-bit number; remaining steps tracked as a plain count.
    typedef struct packed {
        logic [2*W-1:0] acc;
        logic           so;
        logic           done;
        logic           left;
        logic [7:0]     rem;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t shift_step(input mstate_t s, input logic left, input logic cin);
        mstate_t r = s;
        if (left) begin
            r.so  = s.acc[2*W-1];
            r.acc = {s.acc[2*W-2:0], cin};
        end else begin
            r.so  = s.acc[0];
            r.acc = {cin, s.acc[2*W-1:1]};
        end
        return r;
    endfunction

    function automatic mstate_t model_next(input mstate_t s);
        mstate_t r = s;
        int      n;
        r.done = 1'b0;
        if (en && s.rem != 0) begin
            r      = shift_step(r, s.left, carry_in);
            r.rem  = s.rem - 8'd1;
            r.done = (r.rem == 0);
        end else if (en && cmd_valid && s.rem == 0) begin
            r.done = 1'b1;
            case (cmd)
                CMD_LD_AH_EXT: r.acc[2*W-1:W] = ah_in;
                CMD_LD_AH_ALU: r.acc[2*W-1:W] = aludata;
                CMD_XFER:      r.acc[W-1:0]   = s.acc[2*W-1:W];
                CMD_SHL1:      r = shift_step(r, 1'b1, carry_in);
                CMD_SHR1:      r = shift_step(r, 1'b0, carry_in);
                CMD_SHL_N, CMD_SHR_N: begin
                    n      = (int'(shamt) > 2*W) ? 2*W : int'(shamt);
                    r.left = (cmd == CMD_SHL_N);
                    if (n > 0) begin
                        r      = shift_step(r, r.left, carry_in);
                        r.rem  = 8'(n - 1);
                        r.done = (n == 1);
                    end
                end
                default: ;
            endcase
        end
        if (ah_reset) r.acc[2*W-1:W] = '0;
        return r;
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) m <= '0;
        else        m <= model_next(m);
    end

    always @(negedge clk) begin
        if (clr_n === 1'b1) begin
            check("cyc_ah",    32'(ah_out),    32'(m.acc[2*W-1:W]));
            check("cyc_al",    32'(al_out),    32'(m.acc[W-1:0]));
            check("cyc_so",    32'(shift_out), 32'(m.so));
            check("cyc_busy",  32'(busy),      32'(m.rem != 0));
            check("cyc_done",  32'(done),      32'(m.done));
            check("cyc_ready", 32'(cmd_ready), 32'(m.rem == 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] c, input logic [SH_W-1:0] s, input logic cin,
                         input logic [W-1:0] a, input logic [W-1:0] alu);
        cmd       = c;
        shamt     = s;
        carry_in  = cin;
        ah_in     = a;
        aludata   = alu;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic setup_3ca5();
        issue(CMD_LD_AH_EXT, '0, 1'b0, 8'hA5, 8'h00);
        issue(CMD_XFER,      '0, 1'b0, 8'h00, 8'h00);
        issue(CMD_LD_AH_ALU, '0, 1'b0, 8'h00, 8'h3C);
    endtask

    initial begin
        int n;
        clr_n = 1'b0; en = 1'b1; ah_reset = 1'b0; cmd = CMD_NOP; cmd_valid = 1'b0;
        shamt = '0; carry_in = 1'b0; ah_in = '0; aludata = '0;
        repeat (2) @(posedge clk);
        #3 clr_n = 1'b1;
        tick();
        check("rst_pair",  32'({ah_out, al_out}), 32'h0000);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy",  32'(busy), 32'd0);

        issue(CMD_LD_AH_EXT, '0, 1'b0, 8'hA5, 8'h00);
        check("ldext_ah", 32'(ah_out), 32'hA5);
        check("ldext_done", 32'(done), 32'd1);
        issue(CMD_XFER, '0, 1'b0, 8'h00, 8'h00);
        check("xfer_al", 32'(al_out), 32'hA5);
        check("xfer_done", 32'(done), 32'd1);
        issue(CMD_LD_AH_ALU, '0, 1'b0, 8'h00, 8'h3C);
        check("ldalu_pair", 32'({ah_out, al_out}), 32'h3CA5);
        check("ldalu_done", 32'(done), 32'd1);
        issue(CMD_SHL1, '0, 1'b0, 8'h00, 8'h00);
        check("shl1_pair", 32'({ah_out, al_out}), 32'h794A);
        check("shl1_so", 32'(shift_out), 32'd0);
        issue(CMD_NOP, '0, 1'b0, 8'h00, 8'h00);
        check("nop_done", 32'(done), 32'd1);
        check("nop_pair", 32'({ah_out, al_out}), 32'h794A);

        setup_3ca5();
        issue(CMD_SHR_N, SH_W'(3), 1'b1, 8'h00, 8'h00);
        check("shrn_e1", 32'({ah_out, al_out, shift_out, busy}), {14'd0, 16'h9E52, 1'b1, 1'b1});
        tick();
        check("shrn_e2", 32'({ah_out, al_out, shift_out, busy}), {14'd0, 16'hCF29, 1'b0, 1'b1});
        tick();
        check("shrn_e3", 32'({ah_out, al_out, shift_out, busy, done}), {13'd0, 16'hE794, 1'b1, 1'b0, 1'b1});
        tick();
        check("shrn_done_width", 32'(done), 32'd0);

        setup_3ca5();
        issue(CMD_SHR_N, '0, 1'b1, 8'h00, 8'h00);
        check("shrn0", 32'({ah_out, al_out, busy, done}), {14'd0, 16'h3CA5, 1'b0, 1'b1});

        setup_3ca5();
        issue(CMD_SHL_N, SH_W'(20), 1'b0, 8'h00, 8'h00);
        check("sat_busy_start", 32'(busy), 32'd1);
        cmd = CMD_LD_AH_EXT; ah_in = 8'hFF; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n = 1;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check("sat_busy_cycles", 32'(n), 32'd15);
        check("sat_result", 32'({ah_out, al_out, shift_out, done}), {14'd0, 16'h0000, 1'b1, 1'b1});

        setup_3ca5();
        issue(CMD_SHR_N, SH_W'(3), 1'b1, 8'h00, 8'h00);
        en = 1'b0;
        repeat (4) tick();
        check("en_frozen", 32'({ah_out, al_out, busy, done}), {14'd0, 16'h9E52, 1'b1, 1'b0});
        en = 1'b1;
        n = 5;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("en_latency", 32'(n), 32'd7);
        check("en_result", 32'({ah_out, al_out, shift_out}), {15'd0, 16'hE794, 1'b1});

        setup_3ca5();
        ah_reset = 1'b1;
        issue(CMD_SHR1, '0, 1'b0, 8'h00, 8'h00);
        ah_reset = 1'b0;
        check("ahrst_shr1", 32'({ah_out, al_out, shift_out}), {15'd0, 16'h0052, 1'b1});

        setup_3ca5();
        issue(CMD_SHR_N, SH_W'(3), 1'b1, 8'h00, 8'h00);
        ah_reset = 1'b1;
        tick();
        ah_reset = 1'b0;
        check("ahrst_seq_mid", 32'({ah_out, al_out, busy}), {15'd0, 16'h0029, 1'b1});
        tick();
        check("ahrst_seq_end", 32'({ah_out, al_out, shift_out, done}), {14'd0, 16'h8014, 1'b1, 1'b1});

        issue(CMD_SHL_N, SH_W'(10), 1'b1, 8'h00, 8'h00);
        tick();
        #2 clr_n = 1'b0;
        #1;
        check("midrst_outs", 32'({ah_out, al_out, shift_out, busy, done}), 32'd0);
        tick();
        #3 clr_n = 1'b1;
        tick();
        check("postrst_ready", 32'({cmd_ready, busy, ah_out, al_out}), {14'd0, 1'b1, 1'b0, 16'h0000});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
